// File: rtl/minimicro_pkg.sv
// Shared definitions for the minimicro core: default widths, the HALT encoding
// and the fetch FSM state type (also used by the testbench for visibility).
package minimicro_pkg;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MEM_DEPTH = 32;
   localparam logic [DEF_DATA_W-1:0] DEF_HALT_WORD = {DEF_DATA_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the 1-cycle instruction RAM and
// hands each word to the decoder over a valid/ready handshake.
module instr_fetch_unit
   import minimicro_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int                ADDR_W    = $clog2(MEM_DEPTH),
   parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              halted
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] redirect_pc_d;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic              instr_valid_q;
   logic              halted_q;

   // Out-of-range redirect targets only exist for non-power-of-2 depths.
   always_comb begin
      pc_d          = (pc_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
      redirect_pc_d = ({1'b0, redirect_pc} >= (ADDR_W + 1)'(MEM_DEPTH)) ? '0 : redirect_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else if (redirect_valid) begin
         pc_q          <= redirect_pc_d;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         state_q       <= en ? REQ : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (en) state_q <= REQ;
            end
            REQ: begin
               state_q <= WAIT;
            end
            WAIT: begin
               instr_q       <= mem_rdata;
               instr_pc_q    <= pc_q;
               instr_valid_q <= 1'b1;
               state_q       <= HOLD;
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid_q <= 1'b0;
                  if (instr_q == HALT_WORD) begin
                     halted_q <= 1'b1;
                     state_q  <= HALT;
                  end else begin
                     pc_q    <= pc_d;
                     state_q <= en ? REQ : IDLE;
                  end
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr    = pc_q;
   assign mem_we      = 1'b1;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural 1-cycle RAM and
// a scoreboard of expected (instr, instr_pc) pairs popped on each handshake.
module tb_instr_fetch_unit;
   import minimicro_pkg::*;

   typedef struct packed {
      logic [31:0] word;
      logic [4:0]  pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [4:0]  redirect_pc;
   logic [31:0] instr;
   logic [4:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        halted;

   logic [31:0] ram [32];
   exp_t        sbQ [$];
   int          vecCount = 0;
   int          errCount = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_rdata      (mem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read instruction RAM sitting beside the fetch unit.
   always @(posedge clk) begin
      if (mem_we) mem_rdata <= ram[mem_addr];
   end

   // Scoreboard: every accepted instruction must match the queue head.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         vecCount++;
         if (sbQ.size() == 0) begin
            errCount++;
            $display("[TB] FAIL unexpected_instr: got instr=%h pc=%0d, required none", instr, instr_pc);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            if ({instr, instr_pc} !== {e.word, e.pc}) begin
               errCount++;
               $display("[TB] FAIL sb_instr: got instr=%h pc=%0d, required instr=%h pc=%0d",
                        instr, instr_pc, e.word, e.pc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 32; i++) ram[i] = 32'h30 + i;
      ram[31] = 32'hAA;
   endtask

   task automatic do_reset();
      en             = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      rst_n          = 1'b0;
      step(1);
      rst_n          = 1'b1;
   endtask

   task automatic push(input logic [31:0] w, input logic [4:0] p);
      sbQ.push_back('{word: w, pc: p});
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 60 && sbQ.size() != 0; c++) step(1);
      vecCount++;
      if (sbQ.size() != 0) begin
         errCount++;
         $display("[TB] FAIL %s_timeout: got %0d pending, required 0", name, sbQ.size());
         sbQ.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      vecCount++;
      if ({instr_valid, halted, mem_we} !== 3'b001) begin
         errCount++;
         $display("[TB] FAIL reset_flags: got valid/halted/we=%b, required 001", {instr_valid, halted, mem_we});
      end
      vecCount++;
      if ({instr, instr_pc, mem_addr} !== 42'd0) begin
         errCount++;
         $display("[TB] FAIL reset_regs: got instr=%h pc=%0d addr=%0d, required 0", instr, instr_pc, mem_addr);
      end
      do_reset();
      step(3);
      vecCount++;
      if (dut.state_q !== IDLE || mem_addr !== 5'd0 || instr_valid !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL idle_hold: got state=%0d addr=%0d valid=%b, required IDLE 0 0",
                  dut.state_q, mem_addr, instr_valid);
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 4; i++) push(32'h30 + i, 5'(i));
      en = 1'b1;
      instr_ready = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         vecCount++;
         if (instr_valid !== ((k % 3) == 0)) begin
            errCount++;
            $display("[TB] FAIL stream_valid_k%0d: got %b, required %b", k, instr_valid, (k % 3) == 0);
         end
      end
      drain("stream");
      instr_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      push(32'h30, 5'd0);
      push(32'h31, 5'd1);
      push(32'h32, 5'd2);
      en = 1'b1;
      instr_ready = 1'b1;
      step(4);
      instr_ready = 1'b0;
      step(2);
      for (int k = 0; k < 5; k++) begin
         step(1);
         vecCount++;
         if (instr !== 32'h31 || instr_valid !== 1'b1 || mem_addr !== 5'd1 || dut.state_q !== HOLD) begin
            errCount++;
            $display("[TB] FAIL stall_hold_c%0d: got instr=%h valid=%b addr=%0d, required 31 1 1",
                     k, instr, instr_valid, mem_addr);
         end
      end
      instr_ready = 1'b1;
      drain("stall");
      instr_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      push(32'hAA, 5'd31);
      push(32'h30, 5'd0);
      en = 1'b1;
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 5'd31;
      step(1);
      redirect_valid = 1'b0;
      vecCount++;
      if (mem_addr !== 5'd31) begin
         errCount++;
         $display("[TB] FAIL wrap_start: got addr=%0d, required 31", mem_addr);
      end
      for (int c = 0; c < 20 && sbQ.size() > 1; c++) step(1);
      vecCount++;
      if (mem_addr !== 5'd0) begin
         errCount++;
         $display("[TB] FAIL wrap_addr: got addr=%0d, required 0", mem_addr);
      end
      drain("wrap");
      instr_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_halt();
      ram[2] = 32'hFFFF_FFFF;
      do_reset();
      push(32'h30, 5'd0);
      push(32'h31, 5'd1);
      push(32'hFFFF_FFFF, 5'd2);
      en = 1'b1;
      instr_ready = 1'b1;
      drain("halt_run");
      for (int k = 0; k < 10; k++) begin
         vecCount++;
         if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 5'd2) begin
            errCount++;
            $display("[TB] FAIL halt_hold_c%0d: got halted=%b valid=%b addr=%0d, required 1 0 2",
                     k, halted, instr_valid, mem_addr);
         end
         step(1);
      end
      redirect_valid = 1'b1;
      redirect_pc = 5'd0;
      step(1);
      redirect_valid = 1'b0;
      vecCount++;
      if (halted !== 1'b0 || mem_addr !== 5'd0) begin
         errCount++;
         $display("[TB] FAIL halt_exit: got halted=%b addr=%0d, required 0 0", halted, mem_addr);
      end
      push(32'h30, 5'd0);
      drain("halt_restart");
      instr_ready = 1'b0;
      en = 1'b0;
      ram[2] = 32'h32;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      push(32'h30, 5'd0);
      push(32'h35, 5'd5);
      en = 1'b1;
      instr_ready = 1'b1;
      for (int c = 0; c < 20 && sbQ.size() > 1; c++) step(1);
      step(1);
      vecCount++;
      if (dut.state_q !== WAIT || mem_addr !== 5'd1) begin
         errCount++;
         $display("[TB] FAIL rwait_state: got state=%0d addr=%0d, required WAIT 1", dut.state_q, mem_addr);
      end
      redirect_valid = 1'b1;
      redirect_pc = 5'd5;
      step(1);
      redirect_valid = 1'b0;
      vecCount++;
      if (instr_valid !== 1'b0 || mem_addr !== 5'd5) begin
         errCount++;
         $display("[TB] FAIL rwait_drop: got valid=%b addr=%0d, required 0 5", instr_valid, mem_addr);
      end
      drain("rwait");
      instr_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_redirect_hold();
      do_reset();
      en = 1'b1;
      for (int c = 0; c < 10 && !instr_valid; c++) step(1);
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 5'd4;
      step(1);
      redirect_valid = 1'b0;
      vecCount++;
      if (mem_addr !== 5'd4 || instr_valid !== 1'b0) begin
         errCount++;
         $display("[TB] FAIL rhold_win: got addr=%0d valid=%b, required 4 0", mem_addr, instr_valid);
      end
      push(32'h34, 5'd4);
      drain("rhold");
      instr_ready = 1'b0;
      en = 1'b0;
   endtask

   task automatic test_reset_hold();
      do_reset();
      en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 5'd3;
      step(1);
      redirect_valid = 1'b0;
      for (int c = 0; c < 10 && !instr_valid; c++) step(1);
      vecCount++;
      if (instr_valid !== 1'b1 || instr !== 32'h33 || instr_pc !== 5'd3) begin
         errCount++;
         $display("[TB] FAIL rhold_pre: got valid=%b instr=%h pc=%0d, required 1 33 3", instr_valid, instr, instr_pc);
      end
      rst_n = 1'b0;
      #1;
      vecCount++;
      if (instr_valid !== 1'b0 || halted !== 1'b0 || instr !== 32'd0) begin
         errCount++;
         $display("[TB] FAIL async_reset_out: got valid=%b halted=%b instr=%h, required 0 0 0", instr_valid, halted, instr);
      end
      vecCount++;
      if (mem_addr !== 5'd0 || instr_pc !== 5'd0 || dut.state_q !== IDLE) begin
         errCount++;
         $display("[TB] FAIL async_reset_pc: got addr=%0d ipc=%0d state=%0d, required 0 0 IDLE",
                  mem_addr, instr_pc, dut.state_q);
      end
      en = 1'b0;
      step(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      en             = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      fill_ram();
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_halt();
      test_redirect_wait();
      test_redirect_hold();
      test_reset_hold();
      vecCount++;
      if (sbQ.size() != 0) begin
         errCount++;
         $display("[TB] FAIL sb_leftover: got %0d entries, required 0", sbQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
